// File: rtl/bist_apb_pkg.sv
// Shared definitions for the BIST APB requester and the execution-block completer.
package bist_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    // Status register polled automatically when the BIST error interrupt fires.
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h0000_0004;

    // BIST register map of the execution-block completer.
    localparam logic [31:0] BIST_REG_CTRL      = 32'h0000_0000;
    localparam logic [31:0] BIST_REG_STATUS    = 32'h0000_0004;
    localparam logic [31:0] BIST_REG_ERR_CNT   = 32'h0000_0008;
    localparam logic [31:0] BIST_REG_SIGNATURE = 32'h0000_000C;

endpackage

// File: rtl/bist_apb_requester.sv
// APB requester for the BIST execution block: one APB transfer per host command,
// autonomous status read on a BIST error interrupt edge, and a bounded wait for pready.
//
// state  | meaning
// IDLE   | waiting for an auto-poll or a host command
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response held until the host consumes it
module bist_apb_requester
    import bist_apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16,
    parameter logic [AddrWidth-1:0] StatusAddr = AddrWidth'(STATUS_ADDR_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_auto_o,
    input  logic                 bist_error_irq_i,
    output logic                 busy_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pready_i
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    apb_req_state_e state, state_next;

    logic                 irq_q;
    logic                 irq_rise;
    logic                 auto_pend;
    logic                 auto_flag;
    logic [CntWidth-1:0]  cnt;
    logic                 wr_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;

    logic launch_auto;
    logic launch_cmd;
    logic done_ok;
    logic done_to;

    assign irq_rise = bist_error_irq_i & ~irq_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; auto-poll outranks a host command waiting in IDLE.
    always_comb begin
        state_next  = state;
        launch_auto = 1'b0;
        launch_cmd  = 1'b0;
        done_ok     = 1'b0;
        done_to     = 1'b0;
        case (state)
            IDLE: begin
                if (auto_pend) begin
                    launch_auto = 1'b1;
                    state_next  = SETUP;
                end else if (cmd_valid_i) begin
                    launch_cmd = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (cnt == CntLast) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // IRQ edge capture, transfer latches, timeout counter and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q     <= 1'b0;
            auto_pend <= 1'b0;
            auto_flag <= 1'b0;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            irq_q <= bist_error_irq_i;

            // A new edge in the launch cycle must not be lost, so set beats clear.
            if (irq_rise) begin
                auto_pend <= 1'b1;
            end else if (launch_auto) begin
                auto_pend <= 1'b0;
            end

            if (launch_auto) begin
                auto_flag <= 1'b1;
                wr_q      <= 1'b0;
                addr_q    <= StatusAddr;
                wdata_q   <= '0;
            end else if (launch_cmd) begin
                auto_flag <= 1'b0;
                wr_q      <= cmd_write_i;
                addr_q    <= cmd_addr_i;
                wdata_q   <= cmd_wdata_i;
            end

            if (launch_auto || launch_cmd) begin
                cnt <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + CntWidth'(1);
            end

            if (done_ok) begin
                rdata_q <= wr_q ? '0 : prdata_i;
                err_q   <= 1'b0;
            end else if (done_to) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Held low during reset so every output reads 0 while rst_i is asserted.
    assign cmd_ready_o = (state == IDLE) && !auto_pend && !rst_i;
    assign busy_o      = (state != IDLE);
    assign psel_o      = (state == SETUP) || (state == ACCESS);
    assign penable_o   = (state == ACCESS);
    assign pwrite_o    = wr_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign rsp_auto_o  = auto_flag;

endmodule

// File: tb/tb_bist_apb_requester.sv
// Directed bench for bist_apb_requester with a small reactive APB completer.
module tb_bist_apb_requester;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_auto_o;
    logic        bist_error_irq_i;
    logic        busy_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i = 1'b0;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cfg_waits = 0;
    logic [31:0] cfg_rdata = 32'h0;
    int          acc_cnt = 0;

    bist_apb_requester dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_write_i      (cmd_write_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_wdata_i      (cmd_wdata_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .rsp_auto_o       (rsp_auto_o),
        .bist_error_irq_i (bist_error_irq_i),
        .busy_o           (busy_o),
        .paddr_o          (paddr_o),
        .psel_o           (psel_o),
        .penable_o        (penable_o),
        .pwrite_o         (pwrite_o),
        .pwdata_o         (pwdata_o),
        .prdata_i         (prdata_i),
        .pready_i         (pready_i)
    );

    always #5 clk_i = ~clk_i;

    assign prdata_i = cfg_rdata;

    // Completer: pready after cfg_waits wait states; negative cfg_waits never answers.
    always @(negedge clk_i) begin
        if (psel_o && penable_o) begin
            acc_cnt  = acc_cnt + 1;
            pready_i = (cfg_waits >= 0) && (acc_cnt > cfg_waits);
        end else begin
            acc_cnt  = 0;
            pready_i = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command from the current negedge; returns in the SETUP cycle.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_accepted", 64'(n < 50), 64'd1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // Called in the SETUP cycle (cycle 1 after accept); stops in the RESP cycle.
    task automatic wait_rsp(output int lat, output int n_sel, output int n_en);
        lat   = 1;
        n_sel = 0;
        n_en  = 0;
        while (!rsp_valid_o && lat < 60) begin
            if (psel_o) n_sel++;
            if (penable_o) n_en++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ns, ne;
        int cnt_v, cnt_s, cnt_r, cnt_same, cnt_busy;
        logic [31:0] saved;

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i = '0;
        cmd_wdata_i = '0;
        rsp_ready_i = 1'b1;
        bist_error_irq_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset_ctrl", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_auto_o, busy_o, cmd_ready_o}, 64'h0);
        chk("reset_data", {paddr_o, pwdata_o}, 64'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ready", cmd_ready_o, 1);

        // Zero-wait write
        cfg_waits = 0;
        cfg_rdata = 32'h1357_9BDF;
        send(1'b1, 32'h0, 32'hA5A5_0001);
        chk("wr_setup", {psel_o, penable_o, pwrite_o}, 64'b101);
        chk("wr_addr_data", {paddr_o, pwdata_o}, 64'h0000_0000_A5A5_0001);
        wait_rsp(lat, ns, ne);
        chk("wr_latency", lat, 3);
        chk("wr_access_cycles", ne, 1);
        chk("wr_rsp", {psel_o, rsp_err_o, rsp_auto_o}, 64'b000);
        chk("wr_rdata", rsp_rdata_o, 0);
        @(negedge clk_i);
        chk("wr_back_idle", {rsp_valid_o, busy_o, cmd_ready_o}, 64'b001);

        // Read with three wait states
        cfg_waits = 3;
        cfg_rdata = 32'hDEAD_BEEF;
        send(1'b0, 32'h4, 32'h0);
        chk("rd_setup", {psel_o, penable_o, pwrite_o, paddr_o}, {3'b100, 32'h4});
        wait_rsp(lat, ns, ne);
        chk("rd_latency", lat, 6);
        chk("rd_psel_cycles", ns, 5);
        chk("rd_access_cycles", ne, 4);
        chk("rd_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", rsp_err_o, 0);
        @(negedge clk_i);

        // Timeout, then a normal transfer
        cfg_waits = -1;
        send(1'b0, 32'h8, 32'h0);
        wait_rsp(lat, ns, ne);
        chk("to_latency", lat, 18);
        chk("to_access_cycles", ne, 16);
        chk("to_rsp", {psel_o, rsp_err_o}, 64'b01);
        chk("to_rdata", rsp_rdata_o, 0);
        @(negedge clk_i);
        cfg_waits = 1;
        send(1'b1, 32'hC, 32'h0000_1234);
        wait_rsp(lat, ns, ne);
        chk("after_to_latency", lat, 4);
        chk("after_to_err", rsp_err_o, 0);
        @(negedge clk_i);

        // IRQ vs host read; three extra pulses merge into one auto read
        cfg_waits = 6;
        cfg_rdata = 32'h0000_00E1;
        bist_error_irq_i = 1'b1;
        @(negedge clk_i);
        chk("irq_blocks_cmd", cmd_ready_o, 0);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h10;
        @(negedge clk_i);
        chk("auto1_setup", {psel_o, penable_o, pwrite_o, cmd_ready_o, paddr_o}, {4'b1000, 32'h4});
        fork
            wait_rsp(lat, ns, ne);
            begin
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk_i);
                    bist_error_irq_i = (i % 2 == 1);
                end
            end
        join
        chk("auto1_latency", lat, 9);
        chk("auto1_rsp", {rsp_auto_o, rsp_err_o, rsp_rdata_o}, {2'b10, 32'h0000_00E1});
        cfg_waits = 0;
        @(negedge clk_i);
        chk("host_held", {cmd_ready_o, busy_o}, 64'b00);
        @(negedge clk_i);
        chk("auto2_setup", {psel_o, paddr_o}, {1'b1, 32'h4});
        wait_rsp(lat, ns, ne);
        chk("auto2_rsp", {rsp_auto_o, 6'(lat)}, {1'b1, 6'd3});
        @(negedge clk_i);
        chk("host_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("host_setup", {psel_o, paddr_o}, {1'b1, 32'h10});
        wait_rsp(lat, ns, ne);
        chk("host_rsp", {rsp_auto_o, 6'(lat)}, {1'b0, 6'd3});
        cnt_busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (busy_o) cnt_busy++;
        end
        chk("no_third_auto", cnt_busy, 0);

        // Response backpressure
        rsp_ready_i = 1'b0;
        cfg_rdata = 32'h5555_AAAA;
        send(1'b0, 32'h4, 32'h0);
        wait_rsp(lat, ns, ne);
        saved = rsp_rdata_o;
        chk("bp_rdata", saved, 32'h5555_AAAA);
        cnt_v = 0; cnt_s = 0; cnt_r = 0; cnt_same = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) cnt_v++;
            if (psel_o) cnt_s++;
            if (cmd_ready_o) cnt_r++;
            if (rsp_rdata_o == saved && !rsp_err_o) cnt_same++;
        end
        chk("bp_valid_held", cnt_v, 5);
        chk("bp_no_psel", cnt_s, 0);
        chk("bp_no_ready", cnt_r, 0);
        chk("bp_fields_stable", cnt_same, 5);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_released", {rsp_valid_o, cmd_ready_o}, 64'b01);

        // Reset mid-ACCESS
        cfg_waits = -1;
        send(1'b1, 32'h8, 32'h1111_2222);
        @(negedge clk_i);
        chk("rst_in_access", penable_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_ctrl", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_auto_o, busy_o, cmd_ready_o}, 64'h0);
        chk("rst_mid_data", {paddr_o, pwdata_o}, 64'h0);
        rst_i = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o || busy_o) cnt_v++;
        end
        chk("rst_no_rsp", cnt_v, 0);
        cfg_waits = 0;
        cfg_rdata = 32'h0BAD_F00D;
        send(1'b0, 32'h4, 32'h0);
        wait_rsp(lat, ns, ne);
        chk("rst_after_rd", {6'(lat), rsp_err_o, rsp_rdata_o}, {6'd3, 1'b0, 32'h0BAD_F00D});
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_apb_requester.md
# bist_apb_requester

APB requester that drives the register port of the BIST-equipped execution block (the `paddr`/`psel`/`penable`/`pwrite`/`pwdata`/`prdata`/`pready` completer). It turns single host commands into APB transfers and returns one response per command. When the BIST error interrupt fires, it autonomously reads the BIST status register. A timeout terminates hung transfers, so a faulty completer cannot stall the safety path.

## Interface
Parameters:
- `AddrWidth`, default 32: APB address width.
- `DataWidth`, default 32: APB data width.
- `TimeoutCycles`, default 16: maximum ACCESS-phase cycles waiting for `pready_i`. Minimum 1.
- `StatusAddr`, default 32'h0000_0004: address of the BIST status register, used by auto-poll.

Ports:
- `clk_i` in 1: single clock; everything is sampled on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `cmd_valid_i` in 1: host command valid.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i` and `cmd_ready_o` are both high at an edge.
- `cmd_write_i` in 1: 1 selects write, 0 selects read.
- `cmd_addr_i` in AddrWidth: command address.
- `cmd_wdata_i` in DataWidth: write data.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DataWidth: read data. 0 for writes and for timeouts.
- `rsp_err_o` out 1: transfer timed out.
- `rsp_auto_o` out 1: response belongs to an auto-poll read, not a host command.
- `bist_error_irq_i` in 1: BIST error interrupt from the execution block (level).
- `busy_o` out 1: FSM is not in IDLE.
- `paddr_o` out AddrWidth, `psel_o` out 1, `penable_o` out 1, `pwrite_o` out 1, `pwdata_o` out DataWidth: APB requester outputs.
- `prdata_i` in DataWidth, `pready_i` in 1: APB completer returns.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE.** `cmd_ready_o` = 1 only when in IDLE and `auto_pend` = 0.
  - If `auto_pend` = 1: launch a read of `StatusAddr`, clear `auto_pend`, set the internal `auto` flag, go to SETUP.
  - Otherwise, on command handshake: latch write/address/data, clear `auto`, go to SETUP.
  - Auto-poll has priority over a simultaneously valid host command. The host command stays pending because `cmd_ready_o` = 0.
- **SETUP.** `psel_o` = 1, `penable_o` = 0. Address, write and data are driven from the latches. Unconditionally go to ACCESS.
- **ACCESS.** `psel_o` = 1, `penable_o` = 1. The timeout counter increments each cycle.
  - If `pready_i` = 1: capture `prdata_i` for reads (0 for writes), set `rsp_err_o` = 0, go to RESP.
  - If the counter reaches `TimeoutCycles` with `pready_i` still 0: capture rdata = 0, set `rsp_err_o` = 1, go to RESP.
  - `pready_i` on the final counted cycle wins over the timeout.
- **RESP.** `psel_o` = 0, `rsp_valid_o` = 1. Response fields stay stable until `rsp_ready_i` = 1, then go to IDLE. No new APB transfer starts while a response is unconsumed.
- **IRQ capture.** Register `irq_q` holds the previous value of `bist_error_irq_i`.
  - A rising edge (`bist_error_irq_i` & ~`irq_q`) sets `auto_pend` in any state.
  - Multiple edges before the launch merge into one read.
  - An edge in the same cycle as the auto launch re-sets `auto_pend`; set wins over clear.
- `paddr_o`, `pwrite_o` and `pwdata_o` hold their latched values outside SETUP/ACCESS; APB ignores them when `psel_o` = 0.
- **Reset.** All outputs are 0, state = IDLE, `auto_pend` = 0, `irq_q` = 0, counter = 0.
  - Reset mid-transfer drops `psel_o`/`penable_o` at the next edge.
  - The in-flight command is discarded and produces no response.

## Timing
- Command accepted at edge N (state is IDLE during cycle N).
- Cycle N+1: SETUP.
- Cycles N+2 onward: ACCESS.
- Zero-wait completer (`pready_i` = 1 in the first ACCESS cycle): `rsp_valid_o` high in cycle N+3.
- Each wait state adds one cycle.
- Timeout: ACCESS lasts exactly `TimeoutCycles` cycles; `rsp_valid_o` is high in cycle N+2+`TimeoutCycles`.
- Back-to-back throughput: if `rsp_ready_i` is held at 1, RESP lasts one cycle and IDLE one cycle. Minimum of 4 cycles per transfer.
- IRQ edge sampled in IDLE at edge E: SETUP of the auto read in cycle E+2. One cycle is for edge registration, one for launch.
- The timeout counter clears on entry to SETUP. Its width is $clog2(`TimeoutCycles`+1).

## Structure
- Shared package `bist_apb_pkg` holds:
  - the state enum `apb_req_state_e` {IDLE, SETUP, ACCESS, RESP};
  - the default `StatusAddr`;
  - the BIST register offset constants used by the execution-block completer.
- Single module; no sub-module. The IRQ edge detector is inline logic.

## Test plan
- **Zero-wait write.** Write addr 0x0, data 0xA5A5_0001, `pready_i` tied 1 → SETUP then ACCESS with `pwrite_o` = 1; `rsp_valid_o` 3 cycles after accept; `rsp_err_o` = 0; `rsp_rdata_o` = 0.
- **Read with waits.** Read addr 0x4; completer holds `pready_i` = 0 for 3 ACCESS cycles, then returns 0xDEAD_BEEF → `rsp_rdata_o` = 0xDEAD_BEEF; `rsp_valid_o` 6 cycles after accept; `psel_o` stable throughout.
- **Timeout.** `TimeoutCycles` = 16, `pready_i` stuck 0 → exactly 16 ACCESS cycles, then `psel_o` = 0, `rsp_err_o` = 1, `rsp_rdata_o` = 0. The next command then completes normally.
- **IRQ vs host.** `bist_error_irq_i` rises while a host read is valid in IDLE → auto read of `StatusAddr` first (`rsp_auto_o` = 1), then the host read (`rsp_auto_o` = 0). Three IRQ pulses during the first transfer yield only one extra auto read.
- **Response backpressure.** `rsp_ready_i` = 0 for 5 cycles → response fields unchanged; `cmd_ready_o` = 0; no `psel_o` assertion.
- **Reset mid-ACCESS.** `rst_i` pulsed for 1 cycle → next cycle all outputs are 0 and state is IDLE; no response is generated; a following read to 0x4 succeeds.
